// File: rtl/pid_core_mc.sv
// Time-multiplexed PID (second-order IIR) controller for NUM_CH loops.
// One bit-serial multiplier walks the five terms of each channel in turn;
// the clamped accumulator feeds both the stored y history (anti-windup)
// and the integer channel output.
module pid_core_mc #(
  parameter int NUM_CH        = 2,
  parameter int ADC_BITWIDTH  = 8,
  parameter int REG_BITWIDTH  = 16,
  parameter int FRAC_BITWIDTH = 12,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rstn_i,
  input  logic                                  start_i,
  input  logic                                  clear_i,
  input  logic [NUM_CH-1:0]                     ch_en_i,
  input  logic [NUM_CH*ADC_BITWIDTH-1:0]        adc_bus_i,
  input  logic [NUM_CH*ADC_BITWIDTH-1:0]        set_bus_i,
  input  logic signed [REG_BITWIDTH-1:0]        b0_i,
  input  logic signed [REG_BITWIDTH-1:0]        b1_i,
  input  logic signed [REG_BITWIDTH-1:0]        b2_i,
  input  logic signed [REG_BITWIDTH-1:0]        a1_i,
  input  logic signed [REG_BITWIDTH-1:0]        a2_i,
  output logic [NUM_CH*(ADC_BITWIDTH+1)-1:0]    out_bus_o,
  output logic                                  out_valid_o,
  output logic [CH_W-1:0]                       out_ch_o,
  output logic                                  busy_o,
  output logic                                  done_o,
  output logic                                  overrun_o
);

  localparam int E_W   = ADC_BITWIDTH + 1;
  localparam int Y_W   = ADC_BITWIDTH + 1 + FRAC_BITWIDTH;
  localparam int ACC_W = REG_BITWIDTH + ADC_BITWIDTH + 1 + FRAC_BITWIDTH + 3;
  localparam int K_W   = (REG_BITWIDTH > 1) ? $clog2(REG_BITWIDTH) : 1;
  localparam logic signed [ACC_W-1:0] SAT_HI =
    ACC_W'((2 ** ADC_BITWIDTH) - 1) <<< (2 * FRAC_BITWIDTH);
  localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, SAT, WRITE, DONE} state_t;

  state_t state, state_nx;

  logic [NUM_CH*ADC_BITWIDTH-1:0] adc_cap, set_cap;
  logic [NUM_CH-1:0]              en_cap;
  logic signed [REG_BITWIDTH-1:0] b0_c, b1_c, b2_c, a1_c, a2_c;
  logic [CH_W-1:0]                ch;
  logic [2:0]                     term, term_sel;
  logic [K_W-1:0]                 bit_idx;
  logic signed [ACC_W-1:0]        acc, mcand, mcand_sel;
  logic signed [REG_BITWIDTH-1:0] coef, coef_sel;
  logic signed [Y_W-1:0]          y_new;
  logic signed [E_W-1:0]          e_now;
  logic                           clr_pend, last_bit, last_ch, wipe;

  logic signed [E_W-1:0] e1 [NUM_CH];
  logic signed [E_W-1:0] e2 [NUM_CH];
  logic signed [Y_W-1:0] y1 [NUM_CH];
  logic signed [Y_W-1:0] y2 [NUM_CH];

  // Clamp to the symmetric output range and keep FRAC fractional bits.
  function automatic logic signed [Y_W-1:0] sat_state(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] c;
    c = v;
    if (v > SAT_HI) c = SAT_HI;
    else if (v < SAT_LO) c = SAT_LO;
    return Y_W'(c >>> FRAC_BITWIDTH);
  endfunction

  // Integer output: drop the remaining fractional bits (floor toward -inf).
  function automatic logic signed [E_W-1:0] out_of_state(input logic signed [Y_W-1:0] y);
    return E_W'(y >>> FRAC_BITWIDTH);
  endfunction

  assign last_bit  = (bit_idx == K_W'(REG_BITWIDTH - 1));
  assign last_ch   = (ch == CH_W'(NUM_CH - 1));
  // A start during a frame is refused; the refusal is flagged combinationally.
  assign overrun_o = rstn_i & start_i & busy_o;
  // History wipe: immediate in IDLE, otherwise deferred to the done edge.
  assign wipe = (state == IDLE && clear_i) ||
                (((state == WRITE && last_ch) || state == DONE) && (clr_pend || clear_i));

  // Current error and next multiplier operand pair for the active channel.
  always_comb begin
    e_now     = signed'({1'b0, set_cap[ch*ADC_BITWIDTH +: ADC_BITWIDTH]}) -
                signed'({1'b0, adc_cap[ch*ADC_BITWIDTH +: ADC_BITWIDTH]});
    term_sel  = (state == LOAD) ? 3'd0 : term + 3'd1;
    mcand_sel = '0;
    coef_sel  = '0;
    case (term_sel)
      3'd0: begin mcand_sel = ACC_W'(e_now) <<< FRAC_BITWIDTH;  coef_sel = b0_c; end
      3'd1: begin mcand_sel = ACC_W'(e1[ch]) <<< FRAC_BITWIDTH; coef_sel = b1_c; end
      3'd2: begin mcand_sel = ACC_W'(e2[ch]) <<< FRAC_BITWIDTH; coef_sel = b2_c; end
      3'd3: begin mcand_sel = -ACC_W'(y1[ch]);                  coef_sel = a1_c; end
      3'd4: begin mcand_sel = -ACC_W'(y2[ch]);                  coef_sel = a2_c; end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state sequencing: one channel per LOAD..WRITE pass.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_i) state_nx = LOAD;
      LOAD:    state_nx = MAC;
      MAC:     if (term == 3'd4 && last_bit) state_nx = SAT;
      SAT:     state_nx = WRITE;
      WRITE:   state_nx = last_ch ? DONE : LOAD;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Capture, bit-serial MAC, saturation and per-channel write-back.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      out_valid_o <= 1'b0;
      out_ch_o    <= '0;
      out_bus_o   <= '0;
      clr_pend    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        e1[c] <= '0;
        e2[c] <= '0;
        y1[c] <= '0;
        y2[c] <= '0;
      end
    end else begin
      out_valid_o <= 1'b0;
      done_o      <= 1'b0;
      if (busy_o && clear_i) clr_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (clear_i) out_bus_o <= '0;
          if (start_i) begin
            adc_cap <= adc_bus_i;
            set_cap <= set_bus_i;
            en_cap  <= ch_en_i;
            b0_c    <= b0_i;
            b1_c    <= b1_i;
            b2_c    <= b2_i;
            a1_c    <= a1_i;
            a2_c    <= a2_i;
            ch      <= '0;
            busy_o  <= 1'b1;
          end
        end
        LOAD: begin
          acc     <= '0;
          term    <= 3'd0;
          bit_idx <= '0;
          mcand   <= mcand_sel;
          coef    <= coef_sel;
        end
        MAC: begin
          // Coefficient MSB carries negative weight (two's complement).
          if (coef[bit_idx]) acc <= last_bit ? acc - mcand : acc + mcand;
          if (last_bit) begin
            bit_idx <= '0;
            term    <= term + 3'd1;
            mcand   <= mcand_sel;
            coef    <= coef_sel;
          end else begin
            bit_idx <= bit_idx + K_W'(1);
            mcand   <= mcand <<< 1;
          end
        end
        SAT: y_new <= sat_state(acc);
        WRITE: begin
          out_valid_o <= 1'b1;
          out_ch_o    <= ch;
          if (en_cap[ch]) begin
            e2[ch] <= e1[ch];
            e1[ch] <= e_now;
            y2[ch] <= y1[ch];
            y1[ch] <= y_new;
            out_bus_o[ch*E_W +: E_W] <= out_of_state(y_new);
          end else begin
            e1[ch] <= '0;
            e2[ch] <= '0;
            y1[ch] <= '0;
            y2[ch] <= '0;
            out_bus_o[ch*E_W +: E_W] <= '0;
          end
          if (last_ch) done_o <= 1'b1;
          else         ch     <= ch + CH_W'(1);
        end
        DONE: begin
          busy_o   <= 1'b0;
          clr_pend <= 1'b0;
        end
        default: ;
      endcase
      if (wipe) begin
        for (int c = 0; c < NUM_CH; c++) begin
          e1[c] <= '0;
          e2[c] <= '0;
          y1[c] <= '0;
          y2[c] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pid_core_mc.sv
// Bench for pid_core_mc: a driver issues frames and pushes the expected
// per-channel results (from a plain-arithmetic model of the control law)
// into a queue; a monitor pops and compares on every out_valid_o.
`timescale 1ns/1ps
module tb_pid_core_mc;
  localparam int NCH  = 2;
  localparam int ADC  = 8;
  localparam int REG  = 16;
  localparam int FRAC = 12;
  localparam int CHC  = 5 * REG + 3;
  localparam int EW   = ADC + 1;
  localparam int BW   = NCH * ADC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rstn_i, start_i, clear_i;
  logic [NCH-1:0]        ch_en;
  logic [BW-1:0]         adc_bus, set_bus;
  logic signed [REG-1:0] b0, b1, b2, a1, a2;
  logic [NCH*EW-1:0]     out_bus;
  logic                  out_valid, busy, done, overrun;
  logic [0:0]            out_ch;

  pid_core_mc #(.NUM_CH(NCH), .ADC_BITWIDTH(ADC), .REG_BITWIDTH(REG), .FRAC_BITWIDTH(FRAC)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .clear_i(clear_i), .ch_en_i(ch_en),
    .adc_bus_i(adc_bus), .set_bus_i(set_bus),
    .b0_i(b0), .b1_i(b1), .b2_i(b2), .a1_i(a1), .a2_i(a2),
    .out_bus_o(out_bus), .out_valid_o(out_valid), .out_ch_o(out_ch),
    .busy_o(busy), .done_o(done), .overrun_o(overrun));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int ch; longint val; int edge_n; bit last;} exp_t;
  exp_t sb[$];
  exp_t mon_x;
  int checks = 0;
  int errors = 0;

  int cb0, cb1, cb2, ca1, ca2;
  int set_v[NCH];
  int adc_v[NCH];
  longint me1[NCH], me2[NCH], my1[NCH], my2[NCH], mout[NCH];

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic longint out_of(input int c);
    return longint'($signed(out_bus[c*EW +: EW]));
  endfunction

  function automatic int rnd_coef();
    logic signed [REG-1:0] r;
    r = REG'($urandom);
    return int'(r);
  endfunction

  // Reference model: the control law in 64-bit integer arithmetic.
  function automatic void model_clear(input bit outs);
    for (int c = 0; c < NCH; c++) begin
      me1[c] = 0; me2[c] = 0; my1[c] = 0; my2[c] = 0;
      if (outs) mout[c] = 0;
    end
  endfunction

  function automatic void model_chan(input int c, input bit en, input int edge_n);
    longint e, acc, lim;
    exp_t x;
    lim = longint'((1 << ADC) - 1) * (longint'(1) << (2 * FRAC));
    e = longint'(set_v[c] - adc_v[c]);
    if (!en) begin
      me1[c] = 0; me2[c] = 0; my1[c] = 0; my2[c] = 0; mout[c] = 0;
    end else begin
      acc = (longint'(cb0) * e + longint'(cb1) * me1[c] + longint'(cb2) * me2[c])
            * (longint'(1) << FRAC) - longint'(ca1) * my1[c] - longint'(ca2) * my2[c];
      if (acc > lim) acc = lim;
      if (acc < -lim) acc = -lim;
      me2[c] = me1[c]; me1[c] = e;
      my2[c] = my1[c]; my1[c] = acc >>> FRAC;
      mout[c] = acc >>> (2 * FRAC);
    end
    x.ch = c; x.val = mout[c]; x.edge_n = edge_n; x.last = (c == NCH - 1);
    sb.push_back(x);
  endfunction

  // Monitor: every output update must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rstn_i === 1'b1) begin
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          mon_x = sb.pop_front();
          chk("out_ch", longint'(out_ch), mon_x.ch);
          chk("out_val", out_of(mon_x.ch), mon_x.val);
          chk("out_edge", cyc, mon_x.edge_n);
          chk("done_flag", longint'(done), longint'(mon_x.last));
        end
      end else if (done === 1'b1) chk("done_without_valid", 1, 0);
    end
  end

  task automatic drive_coefs();
    b0 = REG'(cb0); b1 = REG'(cb1); b2 = REG'(cb2); a1 = REG'(ca1); a2 = REG'(ca2);
  endtask

  task automatic set_law(input int nb0, input int nb1, input int nb2, input int na1, input int na2);
    cb0 = nb0; cb1 = nb1; cb2 = nb2; ca1 = na1; ca2 = na2;
    drive_coefs();
  endtask

  task automatic clear_idle();
    @(negedge clk);
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
    model_clear(1'b1);
    for (int c = 0; c < NCH; c++) chk("clear_idle_out", out_of(c), 0);
  endtask

  task automatic run_frame(input logic [NCH-1:0] en, input bit clr_start, input bit clr_mid, input bit ovr);
    int cap;
    @(negedge clk);
    for (int c = 0; c < NCH; c++) begin
      adc_bus[c*ADC +: ADC] = ADC'(adc_v[c]);
      set_bus[c*ADC +: ADC] = ADC'(set_v[c]);
    end
    drive_coefs();
    ch_en   = en;
    start_i = 1'b1;
    clear_i = clr_start;
    cap = cyc + 1;
    if (clr_start) model_clear(1'b1);
    for (int c = 0; c < NCH; c++) model_chan(c, en[c], cap + (c + 1) * CHC);
    if (clr_mid) model_clear(1'b0);
    #1;
    chk("overrun_idle", longint'(overrun), 0);
    @(negedge clk);
    start_i = 1'b0;
    clear_i = 1'b0;
    adc_bus = BW'($urandom);
    set_bus = BW'($urandom);
    ch_en   = NCH'($urandom);
    b0 = REG'($urandom); a1 = REG'($urandom); a2 = REG'($urandom);
    chk("busy_after_start", longint'(busy), 1);
    for (int k = 0; k < NCH * CHC + 10; k++) begin
      if (busy !== 1'b1) break;
      @(negedge clk);
      if (ovr && cyc == cap + 9) begin
        start_i = 1'b1;
        #1 chk("overrun_pulse", longint'(overrun), 1);
      end else if (ovr && cyc == cap + 10) begin
        start_i = 1'b0;
        #1 chk("overrun_end", longint'(overrun), 0);
      end
      if (clr_mid) clear_i = (cyc == cap + 50);
    end
    clear_i = 1'b0;
    chk("busy_low", longint'(busy), 0);
    chk("busy_drop_edge", cyc, cap + NCH * CHC + 1);
    drive_coefs();
    for (int c = 0; c < NCH; c++) chk("out_bus_hold", out_of(c), mout[c]);
    repeat (3) @(negedge clk);
  endtask

  task automatic set_inputs(input int s0, input int d0, input int s1, input int d1);
    set_v[0] = s0; adc_v[0] = d0; set_v[1] = s1; adc_v[1] = d1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int aw_exp[5];
    rstn_i = 1'b0; start_i = 1'b0; clear_i = 1'b0; ch_en = '1;
    adc_bus = '0; set_bus = '0;
    set_law(0, 0, 0, 0, 0);
    model_clear(1'b1);
    repeat (3) @(negedge clk);
    chk("rst_out_bus", longint'(out_bus), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_overrun", longint'(overrun), 0);
    chk("rst_out_ch", longint'(out_ch), 0);
    rstn_i = 1'b1;
    @(negedge clk);

    // Proportional-only gain of 1.
    set_law(4096, 0, 0, 0, 0);
    set_inputs(100, 60, 50, 80);
    run_frame(2'b11, 0, 0, 0);
    chk("t1_ch0", out_of(0), 40);
    chk("t1_ch1", out_of(1), -30);

    // Integrator.
    clear_idle();
    set_law(4096, 0, 0, -4096, 0);
    for (int i = 0; i < 4; i++) begin
      set_inputs(110, 100, $urandom_range(0, 255), $urandom_range(0, 255));
      run_frame(2'b11, 0, 0, 0);
      chk("integrator", out_of(0), 10 * (i + 1));
    end

    // Anti-windup: state clamps, so reversal recovers immediately.
    clear_idle();
    aw_exp = '{100, 200, 255, 255, 155};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) set_inputs(200, 100, 0, 100);
      else       set_inputs(0, 100, 100, 0);
      run_frame(2'b11, 0, 0, 0);
      chk("antiwindup", out_of(0), aw_exp[i]);
    end

    // Floor rounding of half-LSB results.
    clear_idle();
    set_law(2048, 0, 0, 0, 0);
    set_inputs(0, 1, 1, 0);
    run_frame(2'b11, 0, 0, 0);
    chk("floor_neg", out_of(0), -1);
    chk("floor_pos", out_of(1), 0);

    // Start during a busy frame is rejected.
    set_law(4096, 0, 0, -4096, 0);
    set_inputs(30, 10, 10, 40);
    run_frame(2'b11, 0, 0, 1);
    repeat (20) @(negedge clk);
    chk("no_restart", longint'(busy), 0);

    // Disabled channel with history, plus a deferred clear.
    clear_idle();
    set_inputs(20, 10, 20, 10);
    run_frame(2'b11, 0, 0, 0);
    run_frame(2'b10, 0, 1, 0);
    chk("masked_ch0", out_of(0), 0);
    chk("masked_ch1", out_of(1), 20);
    run_frame(2'b11, 0, 0, 0);
    chk("after_defer_clr_ch0", out_of(0), 10);
    chk("after_defer_clr_ch1", out_of(1), 10);

    // Clear together with start: frame runs on zeroed history.
    run_frame(2'b11, 0, 0, 0);
    run_frame(2'b11, 1, 0, 0);
    chk("clr_start_ch0", out_of(0), 10);

    // Reset in mid-frame aborts without outputs.
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (30) @(negedge clk);
    rstn_i = 1'b0;
    @(negedge clk);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_out", longint'(out_bus), 0);
    rstn_i = 1'b1;
    model_clear(1'b1);
    repeat (200) @(negedge clk);

    // Randomized frames.
    for (int f = 0; f < 12; f++) begin
      set_law(rnd_coef(), rnd_coef(), rnd_coef(), rnd_coef(), rnd_coef());
      for (int c = 0; c < NCH; c++) begin
        set_v[c] = $urandom_range(0, 255);
        adc_v[c] = $urandom_range(0, 255);
      end
      run_frame(NCH'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0));
    end

    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
